// File: rtl/axis_packet_splitter.sv
// AXI-Stream packet splitter: re-frames an input stream into SAMPLES_PER_PACKET-beat packets
// behind a two-entry (main + skid) registered output buffer.
module axis_packet_splitter #(
    parameter int AXIS_TDATA_WIDTH     = 32,
    parameter int SAMPLES_PER_PACKET   = 256,
    parameter bit DISCARD_FIRST_PACKET = 1'b1,
    parameter bit ALIGN_ON_TLAST       = 1'b1
) (
    input  logic                        axis_aclk,
    input  logic                        axis_reset,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        synced_out,
    output logic                        short_pkt,
    output logic [15:0]                 short_count
);

    localparam int               CNT_W   = (SAMPLES_PER_PACKET > 1) ? $clog2(SAMPLES_PER_PACKET) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLES_PER_PACKET - 1);

    typedef enum logic {SYNC, RUN} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic                        skid_valid;
    logic [AXIS_TDATA_WIDTH-1:0] skid_data;
    logic                        skid_last;

    logic accept;
    logic wr;
    logic present;
    logic out_last;
    logic load_main;
    logic skid_valid_nxt;

    assign accept     = s_axis_tvalid & s_axis_tready;
    assign wr         = accept & (state == RUN);
    assign present    = m_axis_tvalid & m_axis_tready;
    assign out_last   = (cnt == CNT_MAX) | (ALIGN_ON_TLAST & s_axis_tlast);
    assign synced_out = (state == RUN);

    // Main register can take a new beat when it is empty or being drained this cycle;
    // the skid register only fills when main is held and a beat arrives.
    assign load_main      = present | ~m_axis_tvalid;
    assign skid_valid_nxt = load_main ? 1'b0 : (skid_valid | wr);

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state         <= DISCARD_FIRST_PACKET ? SYNC : RUN;
            cnt           <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            short_pkt     <= 1'b0;
            short_count   <= '0;
        end else begin
            s_axis_tready <= ~skid_valid_nxt;
            skid_valid    <= skid_valid_nxt;
            short_pkt     <= 1'b0;

            if ((state == SYNC) && accept && s_axis_tlast) begin
                state <= RUN;
            end

            if (wr) begin
                cnt <= out_last ? '0 : cnt + 1'b1;
                // an input frame ending before the count wraps is reported as short
                if (ALIGN_ON_TLAST && s_axis_tlast && (cnt != CNT_MAX)) begin
                    short_pkt <= 1'b1;
                    if (short_count != 16'hFFFF) begin
                        short_count <= short_count + 16'd1;
                    end
                end
            end

            if (load_main) begin
                if (skid_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_data;
                    m_axis_tlast  <= skid_last;
                end else if (wr) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tlast  <= out_last;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end else if (wr) begin
                skid_data <= s_axis_tdata;
                skid_last <= out_last;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_splitter.sv
// Randomized bench for axis_packet_splitter: three configurations share one input stream and
// are each checked against a frame-position reference model.
module tb_axis_packet_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid;
    logic        s_last;
    logic [31:0] s_data;
    logic        m_ready;

    logic [2:0]  tready;
    logic [2:0]  m_valid;
    logic [2:0]  m_last;
    logic [2:0]  synced;
    logic [2:0]  spkt;
    logic [31:0] m_data [3];
    logic [15:0] scount [3];

    // instance configurations: a = N4/discard/align, b = N4/no discard/no align, c = N1/no discard/align
    int np [3] = '{4, 4, 1};
    bit dp [3] = '{1'b1, 1'b0, 1'b0};
    bit ap [3] = '{1'b1, 1'b0, 1'b1};

    logic [32:0] exp_q [3][$];
    logic [32:0] prev_beat [3];
    bit          m_sync [3];
    bit          exp_pulse [3];
    bit          prev_hold [3];
    bit          after_rst [3];
    int          k [3];
    int          g [3];
    int          exp_cnt [3];
    int          rx [3];
    int          rx_last [3];
    int          pc [3];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rnd_on = 1'b0;

    always #5 clk = ~clk;

    axis_packet_splitter #(.AXIS_TDATA_WIDTH(32), .SAMPLES_PER_PACKET(4),
                           .DISCARD_FIRST_PACKET(1'b1), .ALIGN_ON_TLAST(1'b1)) u_a (
        .axis_aclk(clk), .axis_reset(rst), .s_axis_tready(tready[0]), .s_axis_tdata(s_data),
        .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .m_axis_tready(m_ready),
        .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tlast(m_last[0]),
        .synced_out(synced[0]), .short_pkt(spkt[0]), .short_count(scount[0]));

    axis_packet_splitter #(.AXIS_TDATA_WIDTH(32), .SAMPLES_PER_PACKET(4),
                           .DISCARD_FIRST_PACKET(1'b0), .ALIGN_ON_TLAST(1'b0)) u_b (
        .axis_aclk(clk), .axis_reset(rst), .s_axis_tready(tready[1]), .s_axis_tdata(s_data),
        .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .m_axis_tready(m_ready),
        .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tlast(m_last[1]),
        .synced_out(synced[1]), .short_pkt(spkt[1]), .short_count(scount[1]));

    axis_packet_splitter #(.AXIS_TDATA_WIDTH(32), .SAMPLES_PER_PACKET(1),
                           .DISCARD_FIRST_PACKET(1'b0), .ALIGN_ON_TLAST(1'b1)) u_c (
        .axis_aclk(clk), .axis_reset(rst), .s_axis_tready(tready[2]), .s_axis_tdata(s_data),
        .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .m_axis_tready(m_ready),
        .m_axis_tdata(m_data[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tlast(m_last[2]),
        .synced_out(synced[2]), .short_pkt(spkt[2]), .short_count(scount[2]));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the buffer holds exactly the beats accepted and not yet delivered; output
    // tlast falls every N beats of the frame position (since the last input tlast when aligning,
    // since sync otherwise).
    always @(negedge clk) begin
        logic [32:0] e;
        bit          lst;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_q[i].delete();
                m_sync[i]    = !dp[i];
                k[i]         = 0;
                g[i]         = 0;
                exp_pulse[i] = 1'b0;
                exp_cnt[i]   = 0;
                prev_hold[i] = 1'b0;
                after_rst[i] = 1'b1;
            end else begin
                check_val("s_tready", 64'(tready[i]), 64'(!after_rst[i] && (exp_q[i].size() < 2)));
                after_rst[i] = 1'b0;
                check_val("m_tvalid", 64'(m_valid[i]), 64'(exp_q[i].size() > 0));
                check_val("synced_out", 64'(synced[i]), 64'(m_sync[i]));
                check_val("short_pkt", 64'(spkt[i]), 64'(exp_pulse[i]));
                check_val("short_count", 64'(scount[i]), 64'(exp_cnt[i]));
                if (spkt[i]) pc[i]++;
                if (prev_hold[i])
                    check_val("hold_beat", 64'({m_valid[i], m_last[i], m_data[i]}), 64'({1'b1, prev_beat[i]}));
                prev_hold[i] = m_valid[i] && !m_ready;
                prev_beat[i] = {m_last[i], m_data[i]};
                if (m_valid[i] && m_ready) begin
                    rx[i]++;
                    if (m_last[i]) rx_last[i]++;
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        check_val("beat", 64'({m_last[i], m_data[i]}), 64'(e));
                    end
                end
                exp_pulse[i] = 1'b0;
                if (s_valid && tready[i]) begin
                    if (!m_sync[i]) begin
                        if (s_last) m_sync[i] = 1'b1;
                    end else begin
                        lst = ap[i] ? ((((k[i] + 1) % np[i]) == 0) || s_last) : (((g[i] + 1) % np[i]) == 0);
                        exp_q[i].push_back({lst, s_data});
                        if (ap[i] && s_last && (((k[i] + 1) % np[i]) != 0)) begin
                            exp_pulse[i] = 1'b1;
                            if (exp_cnt[i] < 65535) exp_cnt[i]++;
                        end
                        g[i]++;
                        k[i] = s_last ? 0 : k[i] + 1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit l);
        bit acc;
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            acc = tready[0];
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 1000);
        if (!acc) check_val("send_timeout", 64'(acc), 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("drain", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, l0, p0, c0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val("rst_m_tvalid", 64'(m_valid[i]), 64'd0);
            check_val("rst_m_tdata", 64'(m_data[i]), 64'd0);
            check_val("rst_m_tlast", 64'(m_last[i]), 64'd0);
            check_val("rst_s_tready", 64'(tready[i]), 64'd0);
            check_val("rst_short_pkt", 64'(spkt[i]), 64'd0);
            check_val("rst_short_count", 64'(scount[i]), 64'd0);
            check_val("rst_synced", 64'(synced[i]), 64'(!dp[i]));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // discard the first frame, then two aligned 4-beat packets
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b0);
        check_val("sync_before", 64'(synced[0]), 64'd0);
        send(32'hA2, 1'b1);
        @(negedge clk);
        check_val("sync_after", 64'(synced[0]), 64'd1);
        @(posedge clk);
        #1;
        r0 = rx[0];
        l0 = rx_last[0];
        for (int v = 0; v < 8; v++) send(32'(v), v == 7);
        drain();
        check_val("t1_beats", 64'(rx[0] - r0), 64'd8);
        check_val("t1_lasts", 64'(rx_last[0] - l0), 64'd2);

        // 6-beat input frame on the aligning instance
        r0 = rx[0];
        l0 = rx_last[0];
        p0 = pc[0];
        for (int v = 0; v < 6; v++) send(32'(100 + v), v == 5);
        drain();
        check_val("align_beats", 64'(rx[0] - r0), 64'd6);
        check_val("align_lasts", 64'(rx_last[0] - l0), 64'd2);
        check_val("align_pulses", 64'(pc[0] - p0), 64'd1);
        check_val("align_count", 64'(scount[0]), 64'd1);

        // 6 + 2 beat frames on the non-aligning instance
        do_reset();
        r0 = rx[1];
        l0 = rx_last[1];
        for (int v = 0; v < 6; v++) send(32'(200 + v), v == 5);
        for (int v = 0; v < 2; v++) send(32'(300 + v), v == 1);
        drain();
        check_val("noalign_beats", 64'(rx[1] - r0), 64'd8);
        check_val("noalign_lasts", 64'(rx_last[1] - l0), 64'd2);
        check_val("noalign_pulses", 64'(pc[1]), 64'd0);

        // random valid / ready
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        r0 = rx[0];
        for (int n = 0; n < 1000; n++) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            send($urandom, $urandom_range(0, 5) == 0);
        end
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        m_ready = 1'b1;
        drain();
        check_val("rnd_beats", 64'(rx[0] - r0), 64'd1000);

        // back-to-back throughput with ready held high
        c0 = cyc;
        for (int v = 0; v < 32; v++) send(32'(500 + v), 1'b0);
        check_val("throughput_cycles", 64'(cyc - c0), 64'd32);
        drain();

        // reset with two beats held
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        do_reset();
        @(negedge clk);
        check_val("rst_mid_valid", 64'(m_valid[0]), 64'd0);
        check_val("rst_mid_synced", 64'(synced[0]), 64'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int v = 0; v < 3; v++) send(32'(600 + v), v == 2);
        r0 = rx[0];
        l0 = rx_last[0];
        for (int v = 0; v < 4; v++) send(32'(700 + v), 1'b0);
        drain();
        check_val("restart_beats", 64'(rx[0] - r0), 64'd4);
        check_val("restart_lasts", 64'(rx_last[0] - l0), 64'd1);

        // short_count saturation with single-beat frames
        for (int n = 0; n < 65540; n++) send(32'(n), 1'b1);
        drain();
        check_val("sat_count", 64'(scount[0]), 64'hFFFF);
        check_val("n1_all_last", 64'(rx_last[2]), 64'(rx[2]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
